residual_merge_stream: RTL and testbench
========================================

Name: residual_merge_stream

Overview:
Streaming, lane-parallel tail stage of a residual block. It buffers skip-path beats (x_in) in an internal FIFO and aligns them with conv-path beats (conv2 output). It applies a runtime-selectable end activation to the conv path, adds the residual with optional saturation, and emits the sum through a valid/ready stream. This replaces tensor-wide flattened buses and lets one tensor be processed per start/done transaction at one beat per clock.

Parameters:
DATA_WIDTH, 16, signed two's-complement element width
LANES, 4, elements per beat (channel-parallel lanes)
SKIP_DEPTH, 64, skip FIFO depth in beats; power of 2, at least 2
TOTAL_BEATS, 128, beats per tensor (B*C*H*W/LANES)
CNT_WIDTH, 16, width of beat counters; 2^CNT_WIDTH > TOTAL_BEATS
LEAKY_SHIFT, 3, LeakyReLU slope = 2^-LEAKY_SHIFT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  begin one tensor transaction; sampled in IDLE only
cfg_act  in  2  end activation: 0 identity, 1 ReLU, 2 LeakyReLU, 3 identity
cfg_sat  in  1  1 = saturate sum, 0 = wrap
skip_valid  in  1  skip beat valid
skip_ready  out  1  skip beat accepted when valid&&ready
skip_data  in  LANES*DATA_WIDTH  skip elements, lane 0 in LSBs
res_valid  in  1  conv beat valid
res_ready  out  1  conv beat accepted when valid&&ready
res_data  in  LANES*DATA_WIDTH  conv elements, lane 0 in LSBs
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*DATA_WIDTH  result elements
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of transaction
skip_level  out  $clog2(SKIP_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; FIFO emptied; counters cleared; output stage emptied.
  - All outputs 0: out_data=0, out_valid=0, skip_ready=0, res_ready=0, busy=0, done=0, skip_level=0.
  - Reset mid-transaction discards all in-flight data; no partial done.
- State machine:
  - IDLE: on start==1, latch cfg_act and cfg_sat, clear skip_cnt and res_cnt, go to RUN. Config changes after the latch are ignored until the next start.
  - RUN: on the edge where the TOTAL_BEATS-th res beat is accepted, go to DRAIN.
  - DRAIN: on the edge where the final out beat handshakes, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- Skip path:
  - skip_ready = RUN && !fifo_full && skip_cnt<TOTAL_BEATS.
  - A full FIFO never accepts a push, even if it pops in the same cycle.
  - Skip beats beyond TOTAL_BEATS are refused (skip_ready=0).
- Conv path:
  - res_ready = RUN && !fifo_empty && (!out_valid || out_ready).
  - There is no bypass: an empty FIFO stalls conv beats even if a skip beat arrives in the same cycle.
  - Each accepted res beat pops exactly one FIFO entry; order is preserved.
- Simultaneous push and pop: skip_level is unchanged; both counters increment.
- Datapath, per lane:
  - a = act(res): ReLU -> (res<0 ? 0 : res); Leaky -> (res<0 ? res>>>LEAKY_SHIFT : res) (arithmetic shift, floor).
  - sum = sext(a) + sext(skip) in DATA_WIDTH+1 bits.
  - cfg_sat=1: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. cfg_sat=0: take the low DATA_WIDTH bits.
- Output stage:
  - Single register. Result is registered on the res handshake edge; out_valid is high the next cycle (latency 1).
  - Throughput is 1 beat/clk while out_ready=1.
  - out_data holds stable while out_valid && !out_ready.
  - out_valid clears after a handshake with no new res beat.
- skip_level is registered occupancy (0..SKIP_DEPTH) and updates the cycle after each push or pop.

Optional Feature:
RESBLOCK_SAT_STATS_EN
- Defined: adds output port sat_count [CNT_WIDTH-1:0]. It counts lanes clamped during the current transaction, clears on start, saturates at its maximum, holds after done, and resets to 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan (DATA_WIDTH=16, LANES=4, TOTAL_BEATS=4, LEAKY_SHIFT=3 unless stated):
- Identity, cfg_sat=1: skip {1,2,3,4}, res {10,20,30,40} for 4 beats -> out {11,22,33,44} each beat; out_valid 1 clk after each res handshake; done pulses exactly once, 1 clk after the 4th out handshake.
- Activations, lane values with skip=0: ReLU res -16 -> 0; Leaky res -16 -> -2, res -1 -> -1, res 7 -> 7.
- Saturation: res 0x7FF0 + skip 0x0020 -> 0x7FFF (cfg_sat=1) and 0x8010 (cfg_sat=0); res 0x8000 + skip 0xFFFF -> 0x8000 (cfg_sat=1); with RESBLOCK_SAT_STATS_EN, sat_count=2 after these.
- Backpressure, SKIP_DEPTH=4, TOTAL_BEATS=8:
  - out_ready=0 for 10 clks -> out_data stable, res_ready=0, skip_level reaches 4, skip_ready=0.
  - Release -> all 8 results in order, no loss or duplication.
  - Res offered before any skip -> res_ready=0.
- Limits: after 4 skip beats accepted, skip_ready=0 with FIFO not full; start during RUN ignored (busy and counters unaffected).
- Reset mid-run: rst=0 for 1 clk after beat 2 -> all outputs 0, skip_level=0, no done; new start then processes 4 fresh beats correctly.

Source files
------------

// File: rtl/residual_merge_stream_if.sv
// ============================================================================
// Module      : residual_merge_stream_if
// Description : Bundles the control, skip, conv and result streams of the
//               residual merge stage. The slave modport is the design's view.
//               The master modport is the view of the block that drives it.
//               Optional macro RESBLOCK_SAT_STATS_EN adds the sat_count signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface residual_merge_stream_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
`ifdef RESBLOCK_SAT_STATS_EN
   parameter int CNT_WIDTH  = 16,
`endif
   parameter int SKIP_DEPTH = 64
);
   localparam int BUS_W = LANES * DATA_WIDTH;
   localparam int LVL_W = $clog2(SKIP_DEPTH) + 1;

   logic             start;
   logic [1:0]       cfg_act;
   logic             cfg_sat;
   logic             skip_valid;
   logic             skip_ready;
   logic [BUS_W-1:0] skip_data;
   logic             res_valid;
   logic             res_ready;
   logic [BUS_W-1:0] res_data;
   logic             out_valid;
   logic             out_ready;
   logic [BUS_W-1:0] out_data;
   logic             busy;
   logic             done;
   logic [LVL_W-1:0] skip_level;
`ifdef RESBLOCK_SAT_STATS_EN
   logic [CNT_WIDTH-1:0] sat_count;
`endif

   modport slave (
      input  start, cfg_act, cfg_sat, skip_valid, skip_data,
             res_valid, res_data, out_ready,
`ifdef RESBLOCK_SAT_STATS_EN
      output sat_count,
`endif
      output skip_ready, res_ready, out_valid, out_data, busy, done, skip_level
   );

   modport master (
      output start, cfg_act, cfg_sat, skip_valid, skip_data,
             res_valid, res_data, out_ready,
`ifdef RESBLOCK_SAT_STATS_EN
      input  sat_count,
`endif
      input  skip_ready, res_ready, out_valid, out_data, busy, done, skip_level
   );
endinterface

`default_nettype wire

// File: rtl/residual_merge_stream.sv
// ============================================================================
// Module      : residual_merge_stream
// Description : Residual block tail stage. Skip beats are buffered in a FIFO
//               and each conv beat pops one of them. The conv beat goes through
//               the end activation and is added to its skip beat. The sum is
//               clamped or wrapped, then registered onto a valid/ready output.
//               Optional macro RESBLOCK_SAT_STATS_EN adds a clamped-lane counter.
//               That counter is driven on bus.sat_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module residual_merge_stream #(
   parameter int DATA_WIDTH  = 16,
   parameter int LANES       = 4,
   parameter int SKIP_DEPTH  = 64,
   parameter int TOTAL_BEATS = 128,
   parameter int CNT_WIDTH   = 16,
   parameter int LEAKY_SHIFT = 3
) (
   input wire logic              clk,
   input wire logic              rst,
   residual_merge_stream_if.slave bus
);
   localparam int ADDR_W = $clog2(SKIP_DEPTH);
   localparam int LVL_W  = ADDR_W + 1;
   localparam int BUS_W  = LANES * DATA_WIDTH;
   localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(SKIP_DEPTH);
   localparam logic [CNT_WIDTH-1:0]  BEATS     = CNT_WIDTH'(TOTAL_BEATS);
   localparam logic [CNT_WIDTH-1:0]  LAST_BEAT = CNT_WIDTH'(TOTAL_BEATS - 1);
   localparam logic [DATA_WIDTH-1:0] MAX_VAL   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_VAL   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state;
   logic [1:0]           act_q;
   logic                 sat_q;
   logic [CNT_WIDTH-1:0] skip_cnt;
   logic [CNT_WIDTH-1:0] res_cnt;
   logic                 busy_q;
   logic                 done_q;

   logic [BUS_W-1:0]     fifo_mem [SKIP_DEPTH];
   logic [ADDR_W-1:0]    wr_ptr;
   logic [ADDR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]     level;

   logic                 out_valid_q;
   logic [BUS_W-1:0]     out_data_q;

   logic                 skip_ready_w;
   logic                 res_ready_w;
   logic                 push;
   logic                 pop;
   logic                 out_fire;
   logic [BUS_W-1:0]     skip_head;
   logic [BUS_W-1:0]     sum_bus;
`ifdef RESBLOCK_SAT_STATS_EN
   logic [LANES-1:0]     clamp;
`endif

   // A full FIFO refuses pushes even when it pops in the same cycle.
   // There is no skip-to-conv bypass, so an empty FIFO always stalls conv beats.
   assign skip_ready_w = (state == S_RUN) && (level != FULL_LVL) && (skip_cnt < BEATS);
   assign res_ready_w  = (state == S_RUN) && (level != '0) && (!out_valid_q || bus.out_ready);
   assign push         = bus.skip_valid && skip_ready_w;
   assign pop          = bus.res_valid && res_ready_w;
   assign out_fire     = out_valid_q && bus.out_ready;
   assign skip_head    = fifo_mem[rd_ptr];

   assign bus.skip_ready = skip_ready_w;
   assign bus.res_ready  = res_ready_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.skip_level = level;

   // Per-lane activation, residual add and optional clamp.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] res_e;
      logic signed [DATA_WIDTH-1:0] skip_e;
      logic signed [DATA_WIDTH-1:0] act_e;
      logic        [DATA_WIDTH:0]   sum_e;
      logic                         ovf;

      assign res_e  = bus.res_data[l*DATA_WIDTH +: DATA_WIDTH];
      assign skip_e = skip_head[l*DATA_WIDTH +: DATA_WIDTH];

      // Activation select: codes 0 and 3 both pass the conv value through.
      always_comb begin
         act_e = res_e;
         if (res_e[DATA_WIDTH-1]) begin
            if (act_q == 2'd1)      act_e = '0;
            else if (act_q == 2'd2) act_e = res_e >>> LEAKY_SHIFT;
         end
      end

      assign sum_e = {act_e[DATA_WIDTH-1], act_e} + {skip_e[DATA_WIDTH-1], skip_e};
      // Overflow shows as disagreement between the two top bits of the sum.
      assign ovf   = sat_q && (sum_e[DATA_WIDTH] != sum_e[DATA_WIDTH-1]);
      assign sum_bus[l*DATA_WIDTH +: DATA_WIDTH] =
         ovf ? (sum_e[DATA_WIDTH] ? MIN_VAL : MAX_VAL) : sum_e[DATA_WIDTH-1:0];
`ifdef RESBLOCK_SAT_STATS_EN
      assign clamp[l] = ovf;
`endif
   end

   // Transaction state, latched config and beat counters; busy/done registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         act_q    <= 2'd0;
         sat_q    <= 1'b0;
         skip_cnt <= '0;
         res_cnt  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         if (push) skip_cnt <= skip_cnt + CNT_WIDTH'(1);
         if (pop)  res_cnt  <= res_cnt + CNT_WIDTH'(1);
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  act_q    <= bus.cfg_act;
                  sat_q    <= bus.cfg_sat;
                  skip_cnt <= '0;
                  res_cnt  <= '0;
                  busy_q   <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (pop && (res_cnt == LAST_BEAT)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               // The result register holds only the last beat here.
               if (out_fire) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers and registered occupancy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.skip_data;
   end

   // Single-entry output register: load on conv handshake, hold while stalled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_data_q  <= sum_bus;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef RESBLOCK_SAT_STATS_EN
   logic [CNT_WIDTH-1:0] sat_cnt;
   logic [CNT_WIDTH:0]   sat_sum;

   // Running count plus the lanes clamped on this beat, with a carry-out bit.
   always_comb begin
      sat_sum = {1'b0, sat_cnt};
      for (int i = 0; i < LANES; i++) begin
         sat_sum = sat_sum + {{CNT_WIDTH{1'b0}}, clamp[i]};
      end
   end

   // Clamped-lane counter: cleared on start, saturating, held after done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sat_cnt <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         sat_cnt <= '0;
      end else if (pop) begin
         sat_cnt <= sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
      end
   end

   assign bus.sat_count = sat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_residual_merge_stream.sv
// ============================================================================
// Module      : tb_residual_merge_stream
// Description : Directed bench for residual_merge_stream. The drivers push
//               hand-computed results into a queue. A monitor pops the queue
//               on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_residual_merge_stream;
   localparam int DW = 16;
   localparam int LN = 4;
   localparam int SD = 4;
   localparam int TB = 8;
   localparam int BW = DW * LN;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   residual_merge_stream_if #(.DATA_WIDTH(DW), .LANES(LN), .SKIP_DEPTH(SD)) bus ();

   residual_merge_stream #(
      .DATA_WIDTH(DW), .LANES(LN), .SKIP_DEPTH(SD),
      .TOTAL_BEATS(TB), .CNT_WIDTH(16), .LEAKY_SHIFT(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks     = 0;
   int failures   = 0;
   int hs_count   = 0;
   int target     = -1;
   int done_count = 0;
   bit exp_done_next = 1'b0;
   bit prev_res_hs   = 1'b0;

   logic [BW-1:0] exp_q [$];
   logic [BW-1:0] skip_vec [TB];
   logic [BW-1:0] res_vec  [TB];
   logic [BW-1:0] exp_vec  [TB];

   function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pops, output latency and done-pulse timing.
   always @(negedge clk) begin
      if (!rst) begin
         prev_res_hs   = 1'b0;
         exp_done_next = 1'b0;
      end else begin
         if (bus.done || exp_done_next)
            chk("done_pulse", 64'(bus.done), 64'(exp_done_next));
         if (bus.done) done_count++;
         exp_done_next = 1'b0;
         if (prev_res_hs) chk("out_latency", 64'(bus.out_valid), 64'd1);
         prev_res_hs = bus.res_valid && bus.res_ready;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out: got %h with nothing expected", bus.out_data);
            end else begin
               chk("out_data", bus.out_data, exp_q.pop_front());
            end
            hs_count++;
            if (hs_count == target) exp_done_next = 1'b1;
         end
      end
   end

   task automatic feed_skip(input int first, input int n);
      bit acc;
      int t;
      for (int i = first; i < first + n; i++) begin
         acc = 1'b0;
         t   = 0;
         bus.skip_valid = 1'b1;
         bus.skip_data  = skip_vec[i];
         while (!acc && t < 300) begin
            @(negedge clk);
            acc = bus.skip_ready;
            tick();
            t++;
         end
         if (!acc) begin
            checks++;
            failures++;
            $display("FAIL skip_timeout: beat %0d accepted=0 required=1", i);
         end
      end
      bus.skip_valid = 1'b0;
      bus.skip_data  = '0;
   endtask

   task automatic feed_res(input int first, input int n);
      bit acc;
      int t;
      for (int i = first; i < first + n; i++) begin
         acc = 1'b0;
         t   = 0;
         bus.res_valid = 1'b1;
         bus.res_data  = res_vec[i];
         while (!acc && t < 300) begin
            @(negedge clk);
            acc = bus.res_ready;
            tick();
            t++;
         end
         if (acc) exp_q.push_back(exp_vec[i]);
         else begin
            checks++;
            failures++;
            $display("FAIL res_timeout: beat %0d accepted=0 required=1", i);
         end
      end
      bus.res_valid = 1'b0;
      bus.res_data  = '0;
   endtask

   // Config is inverted right after start to prove it was latched.
   task automatic start_txn(input logic [1:0] act, input logic sat);
      bus.cfg_act = act;
      bus.cfg_sat = sat;
      bus.start   = 1'b1;
      target      = hs_count + TB;
      tick();
      bus.start   = 1'b0;
      bus.cfg_act = ~act;
      bus.cfg_sat = ~sat;
   endtask

   task automatic finish_txn(input int d0);
      int t = 0;
      while (done_count == d0 && t < 400) begin
         tick();
         t++;
      end
      tick();
      tick();
      chk("done_count", 64'(done_count - d0), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
   endtask

   task automatic run_txn(input logic [1:0] act, input logic sat);
      int d0 = done_count;
      start_txn(act, sat);
      fork
         feed_skip(0, TB);
         feed_res(0, TB);
      join
      finish_txn(d0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_out_valid"},  64'(bus.out_valid), 64'd0);
      chk({tag, "_out_data"},   64'(bus.out_data), 64'd0);
      chk({tag, "_skip_ready"}, 64'(bus.skip_ready), 64'd0);
      chk({tag, "_res_ready"},  64'(bus.res_ready), 64'd0);
      chk({tag, "_busy"},       64'(bus.busy), 64'd0);
      chk({tag, "_done"},       64'(bus.done), 64'd0);
      chk({tag, "_skip_level"}, 64'(bus.skip_level), 64'd0);
   endtask

   task automatic bp_test();
      int d0 = done_count;
      bit cap = 1'b0;
      bit stable = 1'b1;
      logic [BW-1:0] held = '0;
      bus.out_ready = 1'b0;
      start_txn(2'd0, 1'b1);
      fork
         begin
            repeat (3) tick();
            feed_skip(0, TB);
         end
         feed_res(0, TB);
         begin
            @(negedge clk);
            chk("res_before_skip", 64'(bus.res_ready), 64'd0);
            for (int c = 0; c < 14; c++) begin
               if (bus.out_valid) begin
                  if (!cap) begin
                     cap  = 1'b1;
                     held = bus.out_data;
                  end else if (bus.out_data !== held) begin
                     stable = 1'b0;
                  end
               end
               @(negedge clk);
            end
            chk("bp_out_valid",  64'(bus.out_valid), 64'd1);
            chk("bp_out_stable", 64'(stable), 64'd1);
            chk("bp_held_beat0", 64'(held), 64'(exp_vec[0]));
            chk("bp_res_ready",  64'(bus.res_ready), 64'd0);
            chk("bp_skip_level", 64'(bus.skip_level), 64'd4);
            chk("bp_skip_ready", 64'(bus.skip_ready), 64'd0);
            tick();
            bus.out_ready = 1'b1;
         end
      join
      finish_txn(d0);
   endtask

   task automatic limits_test();
      int d0 = done_count;
      start_txn(2'd0, 1'b1);
      fork
         feed_skip(0, TB);
         feed_res(0, 6);
      join
      @(negedge clk);
      chk("lim_skip_level", 64'(bus.skip_level), 64'd2);
      chk("lim_skip_ready", 64'(bus.skip_ready), 64'd0);
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      chk("lim_busy_after_start", 64'(bus.busy), 64'd1);
      chk("lim_level_after_start", 64'(bus.skip_level), 64'd2);
      tick();
      feed_res(6, 2);
      finish_txn(d0);
   endtask

   task automatic reset_test();
      bus.out_ready = 1'b0;
      start_txn(2'd0, 1'b1);
      fork
         feed_skip(0, 3);
         feed_res(0, 1);
      join
      @(negedge clk);
      chk("pre_rst_level", 64'(bus.skip_level), 64'd2);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_q.delete();
      target = hs_count;
      @(negedge clk);
      check_zero_outputs("midrst");
      tick();
      bus.out_ready = 1'b1;
      repeat (5) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start      = 1'b0;
      bus.cfg_act    = 2'd0;
      bus.cfg_sat    = 1'b0;
      bus.skip_valid = 1'b0;
      bus.skip_data  = '0;
      bus.res_valid  = 1'b0;
      bus.res_data   = '0;
      bus.out_ready  = 1'b1;
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("reset");

      // Identity with saturation enabled
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = pk(1, 2, 3, 4);
         res_vec[i]  = pk(10, 20, 30, 40);
         exp_vec[i]  = pk(11, 22, 33, 44);
      end
      run_txn(2'd0, 1'b1);

      // ReLU, skip zero
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = '0;
         res_vec[i]  = pk(-16, 7, -1, 0);
         exp_vec[i]  = pk(0, 7, 0, 0);
      end
      run_txn(2'd1, 1'b1);

      // LeakyReLU, floor arithmetic shift by 3
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = '0;
         res_vec[i]  = pk(-16, -1, 7, -9);
         exp_vec[i]  = pk(-2, -1, 7, -2);
      end
      run_txn(2'd2, 1'b1);

      // Activation code 3 behaves as identity
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = pk(1, 1, 1, 1);
         res_vec[i]  = pk(-16, -1, 7, -9);
         exp_vec[i]  = pk(-15, 0, 8, -8);
      end
      run_txn(2'd3, 1'b0);

      // Saturation on beat 0; later beats tag their order in lane 0
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = '0;
         res_vec[i]  = pk(i, 0, 0, 0);
         exp_vec[i]  = pk(i, 0, 0, 0);
      end
      skip_vec[0] = pk(32'h0020, 32'hFFFF, -3, 0);
      res_vec[0]  = pk(32'h7FF0, 32'h8000, 5, 0);
      exp_vec[0]  = pk(32'h7FFF, 32'h8000, 2, 0);
      run_txn(2'd0, 1'b1);
`ifdef RESBLOCK_SAT_STATS_EN
      chk("sat_count_clamp", 64'(bus.sat_count), 64'd2);
`endif
      exp_vec[0] = pk(32'h8010, 32'h7FFF, 2, 0);
      run_txn(2'd0, 1'b0);
`ifdef RESBLOCK_SAT_STATS_EN
      chk("sat_count_wrap", 64'(bus.sat_count), 64'd0);
`endif

      // Backpressure with distinct beats
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = pk(i, i + 1, i + 2, i + 3);
         res_vec[i]  = pk(100 * i, 100 * i + 1, -5 * i, 7);
         exp_vec[i]  = pk(101 * i, 101 * i + 2, -4 * i + 2, i + 10);
      end
      bp_test();

      // Skip limit and start ignored during RUN
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = pk(i, 0, 0, 0);
         res_vec[i]  = pk(0, i, 0, 0);
         exp_vec[i]  = pk(i, i, 0, 0);
      end
      limits_test();

      // Reset mid-transaction, then a fresh transaction
      for (int i = 0; i < TB; i++) begin
         skip_vec[i] = pk(i + 1, 5, 0, -1);
         res_vec[i]  = pk(3, 2 * i, -7, 1);
         exp_vec[i]  = pk(i + 4, 2 * i + 5, -7, 0);
      end
      reset_test();
      run_txn(2'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
